// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit packet sequencer.
// Build option: USB_TX_CRC_GEN_EN enables on-chip CRC16 generation.
package usb_tx_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_SYNC,
    S_PID,
    S_DATA,
    S_CRC_LO,
    S_CRC_HI,
    S_EOP_SE0,
    S_EOP_J
  } tx_state_e;

  localparam logic [7:0]  SYNC_BYTE  = 8'h80;
  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  // Bits go out LSB first, so the register runs in reflected form.
  function automatic logic [15:0] crc16_byte(
    input logic [15:0] crc,
    input logic [7:0]  d
  );
    logic [15:0] c;
    logic [15:0] rp;
    for (int i = 0; i < 16; i++) begin
      rp[i] = CRC16_POLY[15-i];
    end
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ rp;
      else             c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/usb_tx_packet_ctrl_crc16.sv
// Byte-wide USB CRC16 accumulator over the payload.
// Used only when USB_TX_CRC_GEN_EN is defined.
module usb_crc16
  import usb_tx_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [15:0] crc_out
);

  logic [15:0] crc_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      crc_q <= CRC16_INIT;
    end else if (clear) begin
      crc_q <= CRC16_INIT;
    end else if (byte_valid) begin
      crc_q <= crc16_byte(crc_q, byte_in);
    end
  end

  assign crc_out = crc_q;

endmodule

// File: rtl/usb_tx_packet_ctrl.sv
// Transmit packet sequencer: SYNC, PID, payload, CRC16, EOP.
// Build option: USB_TX_CRC_GEN_EN (else CRC bytes come from the FIFO).
module usb_tx_packet_ctrl
  import usb_tx_pkg::*;
#(
  parameter int MAX_LEN      = 64,
  parameter int BIT_CLKS     = 8,
  parameter int EOP_SE0_BITS = 2
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [3:0] tx_pid,
  input  logic [6:0] tx_len,
  input  logic [7:0] fifo_byte,
  input  logic       fifo_empty,
  output logic       fifo_pop,
  input  logic       byte_req,
  output logic [7:0] FSM_byte,
  output logic       select,
  output logic       load_en,
  output logic       idle,
  output logic       Tim_rst,
  output logic       Tim_en,
  output logic       eop,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam logic [6:0] MAX_LEN_L = 7'(MAX_LEN);
  localparam logic [7:0] SE0_LAST  = 8'(EOP_SE0_BITS*BIT_CLKS-1);
  localparam logic [7:0] J_LAST    = 8'(BIT_CLKS-1);

  tx_state_e  state_q, state_d;
  logic [3:0] pid_q, pid_d;
  logic [6:0] len_q, len_d;
  logic [6:0] sent_q, sent_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] byte_q, byte_d;
  logic       sel_q, sel_d;
  logic       load_q, load_d;
  logic       pop_q, pop_d;
  logic       idle_q, idle_d;
  logic       trst_q, trst_d;
  logic       ten_q, ten_d;
  logic       eop_q, eop_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  logic       is_data;
  logic       to_crc;
  logic       want_fifo;
  logic       fifo_pay;
  logic       start_eop;
  tx_state_e  fifo_next;
  logic [6:0] len_clamp;

`ifdef USB_TX_CRC_GEN_EN
  logic        crc_clr;
  logic        crc_vld;
  logic [15:0] crc_raw;
  logic [15:0] crc_tx;

  usb_crc16 u_crc (
    .clk        (clk),
    .n_rst      (n_rst),
    .clear      (crc_clr),
    .byte_valid (crc_vld),
    .byte_in    (fifo_byte),
    .crc_out    (crc_raw)
  );

  assign crc_tx = ~crc_raw;
`endif

  assign is_data   = (pid_q[1:0] == 2'b11);
  assign len_clamp = (tx_len > MAX_LEN_L) ? MAX_LEN_L : tx_len;

  always_comb begin
    state_d   = state_q;
    pid_d     = pid_q;
    len_d     = len_q;
    sent_d    = sent_q;
    cnt_d     = cnt_q;
    byte_d    = byte_q;
    sel_d     = sel_q;
    load_d    = 1'b0;
    pop_d     = 1'b0;
    idle_d    = idle_q;
    trst_d    = trst_q;
    ten_d     = ten_q;
    eop_d     = eop_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    to_crc    = 1'b0;
    want_fifo = 1'b0;
    fifo_pay  = 1'b0;
    start_eop = 1'b0;
    fifo_next = S_DATA;
`ifdef USB_TX_CRC_GEN_EN
    crc_clr   = 1'b0;
    crc_vld   = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (tx_start && !busy_q) begin
          pid_d   = tx_pid;
          len_d   = len_clamp;
          sent_d  = '0;
          state_d = S_START;
          trst_d  = 1'b0;
          ten_d   = 1'b1;
          byte_d  = SYNC_BYTE;
          sel_d   = 1'b1;
          load_d  = 1'b1;
          busy_d  = 1'b1;
`ifdef USB_TX_CRC_GEN_EN
          crc_clr = 1'b1;
`endif
        end
      end
      S_START: begin
        idle_d  = 1'b0;
        state_d = S_SYNC;
      end
      S_SYNC: begin
        if (byte_req) begin
          byte_d  = {~pid_q, pid_q};
          sel_d   = 1'b1;
          load_d  = 1'b1;
          state_d = S_PID;
        end
      end
      S_PID: begin
        if (byte_req) begin
          if (!is_data) begin
            start_eop = 1'b1;
          end else if (len_q == '0) begin
            to_crc = 1'b1;
          end else begin
            want_fifo = 1'b1;
            fifo_pay  = 1'b1;
            fifo_next = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (byte_req) begin
          if (sent_q == len_q) begin
            to_crc = 1'b1;
          end else begin
            want_fifo = 1'b1;
            fifo_pay  = 1'b1;
            fifo_next = S_DATA;
          end
        end
      end
      S_CRC_LO: begin
        if (byte_req) begin
`ifdef USB_TX_CRC_GEN_EN
          byte_d  = crc_tx[15:8];
          sel_d   = 1'b1;
          load_d  = 1'b1;
          state_d = S_CRC_HI;
`else
          want_fifo = 1'b1;
          fifo_next = S_CRC_HI;
`endif
        end
      end
      S_CRC_HI: begin
        if (byte_req) start_eop = 1'b1;
      end
      S_EOP_SE0: begin
        if (cnt_q == SE0_LAST) begin
          state_d = S_EOP_J;
          eop_d   = 1'b0;
          idle_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_EOP_J: begin
        if (cnt_q == J_LAST) begin
          state_d = S_IDLE;
          ten_d   = 1'b0;
          trst_d  = 1'b1;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (to_crc) begin
`ifdef USB_TX_CRC_GEN_EN
      byte_d  = crc_tx[7:0];
      sel_d   = 1'b1;
      load_d  = 1'b1;
      state_d = S_CRC_LO;
`else
      want_fifo = 1'b1;
      fifo_next = S_CRC_LO;
`endif
    end

    // An empty FIFO at a byte request aborts straight into EOP.
    if (want_fifo) begin
      if (fifo_empty) begin
        err_d     = 1'b1;
        start_eop = 1'b1;
      end else begin
        sel_d   = 1'b0;
        load_d  = 1'b1;
        pop_d   = 1'b1;
        state_d = fifo_next;
        if (fifo_pay) sent_d = sent_q + 7'd1;
`ifdef USB_TX_CRC_GEN_EN
        crc_vld = fifo_pay;
`endif
      end
    end

    if (start_eop) begin
      state_d = S_EOP_SE0;
      eop_d   = 1'b1;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      pid_q   <= '0;
      len_q   <= '0;
      sent_q  <= '0;
      cnt_q   <= '0;
      byte_q  <= 8'h00;
      sel_q   <= 1'b0;
      load_q  <= 1'b0;
      pop_q   <= 1'b0;
      idle_q  <= 1'b1;
      trst_q  <= 1'b1;
      ten_q   <= 1'b0;
      eop_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pid_q   <= pid_d;
      len_q   <= len_d;
      sent_q  <= sent_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      sel_q   <= sel_d;
      load_q  <= load_d;
      pop_q   <= pop_d;
      idle_q  <= idle_d;
      trst_q  <= trst_d;
      ten_q   <= ten_d;
      eop_q   <= eop_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign FSM_byte = byte_q;
  assign select   = sel_q;
  assign load_en  = load_q;
  assign fifo_pop = pop_q;
  assign idle     = idle_q;
  assign Tim_rst  = trst_q;
  assign Tim_en   = ten_q;
  assign eop      = eop_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;
  assign tx_err   = err_q;

endmodule

// File: tb/tb_usb_tx_packet_ctrl.sv
// Directed bench for usb_tx_packet_ctrl with a FIFO and
// byte_transmitter stand-in; covers both USB_TX_CRC_GEN_EN builds.
module tb_usb_tx_packet_ctrl;
  import usb_tx_pkg::*;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       tx_start = 1'b0;
  logic [3:0] tx_pid = 4'h0;
  logic [6:0] tx_len = 7'd0;
  logic [7:0] fifo_byte = 8'h00;
  logic       fifo_empty = 1'b1;
  logic       byte_req = 1'b0;
  logic       fifo_pop;
  logic [7:0] FSM_byte;
  logic       select, load_en, idle;
  logic       Tim_rst, Tim_en, eop;
  logic       tx_busy, tx_done, tx_err;

  int tests = 0;
  int fails = 0;

  logic [7:0] fq[$];
  logic [7:0] loads[$];
  logic       sels[$];
  int pops, eop_cnt, j_cnt, done_cnt, err_cnt;
  int req_div = 0;
  bit seen_eop;
  bit auto_req = 1'b1;

  usb_tx_packet_ctrl dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .tx_start   (tx_start),
    .tx_pid     (tx_pid),
    .tx_len     (tx_len),
    .fifo_byte  (fifo_byte),
    .fifo_empty (fifo_empty),
    .fifo_pop   (fifo_pop),
    .byte_req   (byte_req),
    .FSM_byte   (FSM_byte),
    .select     (select),
    .load_en    (load_en),
    .idle       (idle),
    .Tim_rst    (Tim_rst),
    .Tim_en     (Tim_en),
    .eop        (eop),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_err     (tx_err)
  );

  always #5 clk = ~clk;

  // Transmitter + FIFO stand-in; requests a byte every 6 clocks.
  always @(negedge clk) begin
    logic [7:0] tmp;
    if (n_rst) begin
      if (load_en) begin
        loads.push_back(select ? FSM_byte : fifo_byte);
        sels.push_back(select);
      end
      if (fifo_pop) begin
        pops++;
        if (fq.size() > 0) tmp = fq.pop_front();
      end
      if (eop) begin
        eop_cnt++;
        seen_eop = 1'b1;
      end
      if (seen_eop && !eop && idle && tx_busy && !tx_done) j_cnt++;
      if (tx_done) done_cnt++;
      if (tx_err) err_cnt++;
    end
    fifo_empty = (fq.size() == 0);
    fifo_byte  = (fq.size() > 0) ? fq[0] : 8'h00;
    byte_req   = 1'b0;
    if (auto_req && tx_busy) begin
      req_div++;
      if (req_div >= 6) begin
        byte_req = 1'b1;
        req_div  = 0;
      end
    end
  end

  function automatic logic [15:0] ref_crc(input logic [7:0] b[$],
                                          input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < 8; j++) begin
        if (c[0] ^ b[k][j]) c = (c >> 1) ^ 16'hA001;
        else                c = c >> 1;
      end
    end
    return ~c;
  endfunction

  task automatic clear_rec();
    loads.delete();
    sels.delete();
    pops = 0; eop_cnt = 0; j_cnt = 0;
    done_cnt = 0; err_cnt = 0;
    seen_eop = 1'b0;
  endtask

  task automatic start_pkt(input logic [3:0] p, input logic [6:0] l);
    clear_rec();
    @(negedge clk); #1;
    tx_pid = p; tx_len = l; tx_start = 1'b1;
    @(negedge clk); #1;
    tx_start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk); #1;
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [17:0] got, exp;
    exp = {8'h00, 4'b0011, 6'b000000};
    @(negedge clk); #1;
    got = {FSM_byte, select, load_en, idle, Tim_rst,
           Tim_en, eop, tx_busy, tx_done, tx_err, fifo_pop};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL reset_outs got=%h exp=%h", got, exp);
    end
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ack();
    bit ok;
    logic [7:0] exp[$];
    exp = '{8'h80, 8'hD2};
    fq.delete();
    start_pkt(PID_ACK, 7'd0);
    wait_done(400, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL ack_timeout"); end
    tests++;
    if (loads.size() != exp.size()) begin
      fails++;
      $display("FAIL ack_nloads got=%0d exp=%0d", loads.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < loads.size(); i++) begin
      tests++;
      if (loads[i] !== exp[i] || sels[i] !== 1'b1) begin
        fails++;
        $display("FAIL ack_load%0d got=%h/%b exp=%h/1", i, loads[i], sels[i], exp[i]);
      end
    end
    tests++;
    if (eop_cnt != 16) begin
      fails++; $display("FAIL ack_eop_clks got=%0d exp=16", eop_cnt);
    end
    tests++;
    if (j_cnt != 8) begin
      fails++; $display("FAIL ack_idle_j got=%0d exp=8", j_cnt);
    end
    tests++;
    if (pops != 0 || done_cnt != 1 || err_cnt != 0) begin
      fails++;
      $display("FAIL ack_counts pops=%0d done=%0d err=%0d exp 0/1/0", pops, done_cnt, err_cnt);
    end
    tests++;
    if (tx_busy !== 1'b0 || Tim_rst !== 1'b1 || Tim_en !== 1'b0) begin
      fails++;
      $display("FAIL ack_after busy=%b trst=%b ten=%b exp 0/1/0", tx_busy, Tim_rst, Tim_en);
    end
  endtask

  task automatic test_data0_len0();
    bit ok;
    logic [7:0] exp[$];
    logic       esel[$];
    int         epops;
`ifdef USB_TX_CRC_GEN_EN
    fq.delete();
    exp = '{8'h80, 8'hC3, 8'h00, 8'h00};
    esel = '{1'b1, 1'b1, 1'b1, 1'b1};
    epops = 0;
`else
    fq = '{8'hAA, 8'h55};
    exp = '{8'h80, 8'hC3, 8'hAA, 8'h55};
    esel = '{1'b1, 1'b1, 1'b0, 1'b0};
    epops = 2;
`endif
    start_pkt(PID_DATA0, 7'd0);
    wait_done(400, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL d0_timeout"); end
    tests++;
    if (loads.size() != exp.size()) begin
      fails++;
      $display("FAIL d0_nloads got=%0d exp=%0d", loads.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < loads.size(); i++) begin
      tests++;
      if (loads[i] !== exp[i] || sels[i] !== esel[i]) begin
        fails++;
        $display("FAIL d0_load%0d got=%h/%b exp=%h/%b", i, loads[i], sels[i], exp[i], esel[i]);
      end
    end
    tests++;
    if (pops != epops || done_cnt != 1 || eop_cnt != 16) begin
      fails++;
      $display("FAIL d0_counts pops=%0d done=%0d eop=%0d exp %0d/1/16", pops, done_cnt, eop_cnt, epops);
    end
  endtask

  task automatic test_data1_len4();
    bit ok;
    logic [7:0]  src[$];
    logic [7:0]  exp[$];
    logic        esel[$];
    logic [15:0] c;
    int          epops;
    src = '{8'h01, 8'h02, 8'h03, 8'h04};
    c = ref_crc(src, 4);
`ifdef USB_TX_CRC_GEN_EN
    fq = src;
    exp = '{8'h80, 8'h4B, 8'h01, 8'h02, 8'h03, 8'h04, c[7:0], c[15:8]};
    esel = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    epops = 4;
`else
    fq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h11, 8'h22};
    exp = '{8'h80, 8'h4B, 8'h01, 8'h02, 8'h03, 8'h04, 8'h11, 8'h22};
    esel = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    epops = 6;
`endif
    start_pkt(PID_DATA1, 7'd4);
    wait_done(600, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL d1_timeout"); end
    tests++;
    if (loads.size() != exp.size()) begin
      fails++;
      $display("FAIL d1_nloads got=%0d exp=%0d", loads.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < loads.size(); i++) begin
      tests++;
      if (loads[i] !== exp[i] || sels[i] !== esel[i]) begin
        fails++;
        $display("FAIL d1_load%0d got=%h/%b exp=%h/%b", i, loads[i], sels[i], exp[i], esel[i]);
      end
    end
    tests++;
    if (pops != epops || err_cnt != 0 || done_cnt != 1) begin
      fails++;
      $display("FAIL d1_counts pops=%0d err=%0d done=%0d exp %0d/0/1", pops, err_cnt, done_cnt, epops);
    end
  endtask

  task automatic test_underrun();
    bit ok;
    logic [7:0] exp[$];
    exp = '{8'h80, 8'hC3, 8'h5A};
    fq = '{8'h5A};
    start_pkt(PID_DATA0, 7'd3);
    wait_done(500, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL ur_timeout"); end
    tests++;
    if (loads.size() != exp.size()) begin
      fails++;
      $display("FAIL ur_nloads got=%0d exp=%0d", loads.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < loads.size(); i++) begin
      tests++;
      if (loads[i] !== exp[i]) begin
        fails++;
        $display("FAIL ur_load%0d got=%h exp=%h", i, loads[i], exp[i]);
      end
    end
    tests++;
    if (err_cnt != 1 || pops != 1 || eop_cnt != 16 || done_cnt != 1) begin
      fails++;
      $display("FAIL ur_counts err=%0d pops=%0d eop=%0d done=%0d exp 1/1/16/1", err_cnt, pops, eop_cnt, done_cnt);
    end
  endtask

  task automatic test_busy_start();
    bit ok;
    fq.delete();
    start_pkt(PID_ACK, 7'd0);
    repeat (10) @(negedge clk);
    #1;
    tx_pid = PID_DATA0; tx_len = 7'd5; tx_start = 1'b1;
    @(negedge clk); #1;
    tx_start = 1'b0;
    wait_done(400, ok);
    repeat (30) @(negedge clk);
    #1;
    tests++;
    if (!ok) begin fails++; $display("FAIL busy_timeout"); end
    tests++;
    if (done_cnt != 1 || loads.size() != 2 || tx_busy !== 1'b0) begin
      fails++;
      $display("FAIL busy_ignore done=%0d nloads=%0d busy=%b exp 1/2/0", done_cnt, loads.size(), tx_busy);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [17:0] got, exp;
    exp = {8'h00, 4'b0011, 6'b000000};
    fq = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h7F};
    start_pkt(PID_DATA1, 7'd8);
    for (int i = 0; i < 300 && pops < 2; i++) @(negedge clk);
    tests++;
    if (pops < 2) begin
      fails++; $display("FAIL rmid_reach pops=%0d exp>=2", pops);
    end
    #2;
    n_rst = 1'b0;
    #1;
    got = {FSM_byte, select, load_en, idle, Tim_rst,
           Tim_en, eop, tx_busy, tx_done, tx_err, fifo_pop};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL rmid_outs got=%h exp=%h", got, exp);
    end
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    fq.delete();
    start_pkt(PID_ACK, 7'd0);
    wait_done(400, ok);
    tests++;
    if (!ok || loads.size() != 2 || eop_cnt != 16) begin
      fails++;
      $display("FAIL rmid_next ok=%b nloads=%0d eop=%0d exp 1/2/16", ok, loads.size(), eop_cnt);
    end
    tests++;
    if (loads.size() == 2 && (loads[0] !== 8'h80 || loads[1] !== 8'hD2)) begin
      fails++;
      $display("FAIL rmid_bytes got=%h %h exp=80 d2", loads[0], loads[1]);
    end
  endtask

  task automatic test_clamp();
    bit ok;
    logic [7:0]  src[$];
    logic [15:0] c;
    int          n;
    src.delete();
    for (int i = 0; i < 70; i++) src.push_back(8'(i * 7 + 3));
    c = ref_crc(src, 64);
    fq = src;
    start_pkt(PID_DATA0, 7'd100);
    wait_done(1500, ok);
    n = loads.size();
    tests++;
    if (!ok) begin fails++; $display("FAIL clamp_timeout"); end
`ifdef USB_TX_CRC_GEN_EN
    tests++;
    if (pops != 64 || n != 68) begin
      fails++;
      $display("FAIL clamp_counts pops=%0d nloads=%0d exp 64/68", pops, n);
    end
    tests++;
    if (n == 68 && (loads[66] !== c[7:0] || loads[67] !== c[15:8])) begin
      fails++;
      $display("FAIL clamp_crc got=%h%h exp=%h", loads[67], loads[66], c);
    end
`else
    tests++;
    if (pops != 66 || n != 68) begin
      fails++;
      $display("FAIL clamp_counts pops=%0d nloads=%0d exp 66/68", pops, n);
    end
    tests++;
    if (n == 68 && (loads[66] !== src[64] || loads[67] !== src[65])) begin
      fails++;
      $display("FAIL clamp_tail got=%h %h exp=%h %h", loads[66], loads[67], src[64], src[65]);
    end
`endif
    fq.delete();
  endtask

`ifndef USB_TX_CRC_GEN_EN
  task automatic test_nogen_len2();
    bit ok;
    logic [7:0] exp[$];
    exp = '{8'h80, 8'h4B, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
    fq = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    start_pkt(PID_DATA1, 7'd2);
    wait_done(500, ok);
    tests++;
    if (!ok || pops != 4 || loads.size() != 6) begin
      fails++;
      $display("FAIL ng_counts ok=%b pops=%0d nloads=%0d exp 1/4/6", ok, pops, loads.size());
    end
    for (int i = 0; i < exp.size() && i < loads.size(); i++) begin
      tests++;
      if (loads[i] !== exp[i] || sels[i] !== (i < 2)) begin
        fails++;
        $display("FAIL ng_load%0d got=%h/%b exp=%h", i, loads[i], sels[i], exp[i]);
      end
    end
  endtask
`endif

  initial begin
    clear_rec();
    test_reset();
    test_ack();
    test_data0_len0();
    test_data1_len4();
    test_underrun();
    test_busy_start();
    test_reset_mid();
    test_clamp();
`ifndef USB_TX_CRC_GEN_EN
    test_nogen_len2();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
